// File: rtl/counter_sched.sv
// Round-robin timer scheduler: grants one of two requesters, loads the shared
// counter with its start value, runs it up to all-ones, then pulses done.
`timescale 1ns/1ps
module counter_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] start_val0,
  input  logic [WIDTH-1:0] start_val1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_out,
  output logic [1:0]       state_dbg
);

  // Handshake: req[i] is held high until done[i] pulses (or is dropped to abort);
  // done[i] is a single-cycle pulse while gnt[i] is still high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic       cur;
  logic       last;
  logic       pick;
  logic [1:0] cur_oh;

  // On a tie the requester not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) pick = ~last;
    else              pick = req[1];
  end

  assign cur_oh = {cur, ~cur};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= 1'b0;
      last     <= 1'b1;
      cnt_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            cur      <= pick;
            cnt_data <= pick ? start_val1 : start_val0;
          end
        end
        LOAD, RUN: begin
          if (!req[cur]) last <= cur;
        end
        DONE: last <= cur;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req != 2'b00) state_nxt = LOAD;
      LOAD: state_nxt = req[cur] ? RUN : IDLE;
      RUN: begin
        if (!req[cur])          state_nxt = IDLE;
        else if (cnt_out == MAX) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Enable stops combinationally at MAX so the counter never wraps.
  always_comb begin
    gnt        = 2'b00;
    done       = 2'b00;
    busy       = (state != IDLE);
    cnt_load   = (state == LOAD);
    cnt_enable = (state == RUN) && (cnt_out != MAX);
    if (state != IDLE) gnt  = cur_oh;
    if (state == DONE) done = cur_oh;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: behavioural counter, directed requests, and a
// queue-based scoreboard checking every done pulse.
`timescale 1ns/1ps
module tb_counter_sched;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] start_val0;
  logic [WIDTH-1:0] start_val1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic             cnt_load;
  logic             cnt_enable;
  logic [WIDTH-1:0] cnt_data;
  logic [WIDTH-1:0] cnt_out;
  logic [1:0]       state_dbg;

  int total = 0;
  int bad   = 0;

  // {done[1:0], latency[4:0], enable_cycles[4:0], load_data[3:0]}
  logic [15:0] exp_q[$];

  counter_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .start_val0(start_val0), .start_val1(start_val1),
    .gnt(gnt), .done(done), .busy(busy),
    .cnt_load(cnt_load), .cnt_enable(cnt_enable), .cnt_data(cnt_data),
    .cnt_out(cnt_out), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Shared counter: load wins over enable, wraps modulo 2^WIDTH.
  always @(posedge clk) begin
    if (rst)             cnt_out <= '0;
    else if (cnt_load)   cnt_out <= cnt_data;
    else if (cnt_enable) cnt_out <= cnt_out + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic [4:0] lat, input logic [4:0] en,
                      input logic [3:0] data);
    exp_q.push_back({d, lat, en, data});
  endtask

  // Monitor: latency counts sample points since gnt rose.
  logic [1:0]  prev_gnt = 2'b00;
  int          lat      = 0;
  int          en_cnt   = 0;
  logic [3:0]  data_seen = '0;
  logic [15:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 2'b00 && prev_gnt == 2'b00) lat = 0;
      else                                    lat++;
      if (cnt_load) begin
        data_seen = cnt_data;
        en_cnt    = 0;
      end
      if (cnt_enable) en_cnt++;
      if (gnt == 2'b11) check("gnt_onehot", {30'd0, gnt}, 32'd0);
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {30'd0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_who",    {30'd0, done},      {30'd0, e[15:14]});
          check("gnt_at_done", {30'd0, gnt},       {30'd0, e[15:14]});
          check("latency",     lat,                {27'd0, e[13:9]});
          check("enables",     en_cnt,             {27'd0, e[8:4]});
          check("load_data",   {28'd0, data_seen}, {28'd0, e[3:0]});
        end
      end
    end
    prev_gnt = gnt;
  end

  // Raise the masked requests, drop each one after it has seen its quota of dones.
  task automatic serve(input logic [1:0] mask, input int need0, input int need1);
    int n0 = need0;
    int n1 = need1;
    @(negedge clk);
    req = mask;
    for (int c = 0; c < 200 && (n0 > 0 || n1 > 0); c++) begin
      @(negedge clk);
      if (done[0] && n0 > 0) begin
        n0--;
        if (n0 == 0) req[0] = 1'b0;
      end
      if (done[1] && n1 > 0) begin
        n1--;
        if (n1 == 0) req[1] = 1'b0;
      end
    end
    if (n0 > 0 || n1 > 0) begin
      check("serve_timeout", n0 + n1, 0);
      req = 2'b00;
    end
  endtask

  task automatic wait_cnt(input logic [3:0] v);
    int c = 0;
    while (!(cnt_out == v && state_dbg == 2'd2) && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) check("wait_cnt_timeout", c, 0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_gnt"},    {30'd0, gnt},      32'd0);
    check({name, "_done"},   {30'd0, done},     32'd0);
    check({name, "_busy"},   {31'd0, busy},     32'd0);
    check({name, "_enable"}, {31'd0, cnt_enable}, 32'd0);
    check({name, "_state"},  {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    start_val0 = '0;
    start_val1 = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_load", {31'd0, cnt_load}, 32'd0);
    check("reset_data", {28'd0, cnt_data}, 32'd0);
    rst = 1'b0;

    // Single requester 0, start 11.
    start_val0 = 4'd11;
    push(2'b01, 5'd6, 5'd4, 4'd11);
    serve(2'b01, 1, 0);
    @(negedge clk);
    check_idle("after_t1");

    // Requester 1 alone, start at MAX: zero enable cycles.
    start_val1 = 4'd15;
    push(2'b10, 5'd2, 5'd0, 4'd15);
    serve(2'b10, 0, 1);

    // Tie with last=1: requester 0 first, then 1.
    start_val0 = 4'd13;
    start_val1 = 4'd14;
    push(2'b01, 5'd4, 5'd2, 4'd13);
    push(2'b10, 5'd3, 5'd1, 4'd14);
    serve(2'b11, 1, 1);

    // Requester 0 keeps req after its done; 1 goes next, then 0 again.
    start_val0 = 4'd12;
    start_val1 = 4'd15;
    push(2'b01, 5'd5, 5'd3, 4'd12);
    push(2'b10, 5'd2, 5'd0, 4'd15);
    push(2'b01, 5'd5, 5'd3, 4'd12);
    serve(2'b11, 2, 1);

    // Abort mid-RUN at cnt_out=5.
    start_val0 = 4'd2;
    @(negedge clk);
    req = 2'b01;
    wait_cnt(4'd5);
    check("abort_pre_enable", {31'd0, cnt_enable}, 32'd1);
    req = 2'b00;
    @(negedge clk);
    check_idle("abort");
    repeat (5) @(negedge clk);

    // Reset mid-RUN, then a tie must go to requester 0.
    start_val0 = 4'd0;
    req = 2'b01;
    wait_cnt(4'd5);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrun_rst");
    check("midrun_rst_data", {28'd0, cnt_data}, 32'd0);
    rst = 1'b0;
    req = 2'b00;
    @(negedge clk);
    start_val0 = 4'd9;
    start_val1 = 4'd10;
    push(2'b01, 5'd8, 5'd6, 4'd9);
    push(2'b10, 5'd7, 5'd5, 4'd10);
    serve(2'b11, 1, 1);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
